ps2_kbd_fifo: RTL
=================

Name: ps2_kbd_fifo

Overview:
- PS/2 keyboard receiver for the DE0 board, directly upstream of the tz80 I/O space.
- Deserialises device-to-host PS/2 frames from PS2_CLK/PS2_DAT and checks start, parity and stop bits.
- Queues good scan-code bytes in a small first-word-fall-through FIFO, which the CPU-side I/O decode pops with a one-cycle read strobe.
- Runs on the 50 MHz system clock, the same clock as zram and tz80.

Parameters:
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW bytes (16).
- FILTER, 8: number of consecutive identical samples (1..255) required before the filtered PS/2 clock/data level changes.
- TIMEOUT_CYC, 5000: clocks without a filtered falling edge, mid-frame, before the frame is aborted. 5000 clocks = 100 us at 50 MHz.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- rd  in  1  pop strobe, one cycle per byte.
- clr  in  1  clears the sticky flags.
- data  out  8  FIFO head byte; valid while ready=1.
- ready  out  1  FIFO non-empty.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- err  out  1  sticky: frame error (start, parity, stop or timeout).
- level  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; all state updates on the rising edge of clock.
- Reset values:
  - ready=0, data=8'h00, overflow=0, err=0, level=0.
  - Frame FSM in IDLE; filter, timeout and bit counters cleared.
  - Filtered clk/dat both reset to 1.
- Reset mid-frame discards the partial frame. Reset does not clear FIFO RAM contents, but pointers are zeroed, so old bytes are never visible.
- Input conditioning:
  - Each pin passes through a 2-FF synchroniser.
  - Per-pin filter: a counter increments while the synced value differs from the filtered value and clears when they match. At FILTER the filtered value flips and the counter clears.
  - A falling edge (fall) is a filtered clk transition 1->0, flagged for exactly one cycle. The filtered data bit is sampled in that same cycle.
- Frame FSM (every transition happens only on fall, except the timeout):
  - IDLE: bit=0 -> DATA with bitcnt=0 and parity accumulator=0. bit=1 -> stay in IDLE (noise, no error).
  - DATA: shift right into sr[7:0], LSB first; parity ^= bit; after the 8th bit -> PARITY.
  - PARITY: ok = (parity ^ bit)==1 (odd parity) -> STOP.
  - STOP: if bit=1 and ok, push sr into the FIFO; otherwise set err and do not push. -> IDLE.
- Timeout:
  - The counter clears on every fall and in IDLE, and increments in all other states.
  - Reaching TIMEOUT_CYC -> IDLE and the partial frame is discarded. See Optional Feature for err.
- FIFO push/pop:
  - Push latency: ready=1 and data=byte in the cycle after the STOP fall.
  - data always shows the head entry, combinationally from the registered read pointer.
  - rd with ready=1: pop; the next byte (or empty) is visible in the following cycle.
  - rd with ready=0: ignored; no pointer change and no flag.
  - Push while full without a same-cycle pop: byte dropped, overflow=1, pointers unchanged.
  - Push and pop in the same cycle: both performed, so level is unchanged and push is accepted even when full.
  - Pointers are FIFO_AW+1 bits and wrap naturally. Full = MSBs differ and the low bits are equal.
- Flags:
  - clr clears overflow and err.
  - If clr coincides with a new set event, the set wins and the flag stays 1.

Optional Feature:
- Macro: PS2_TIMEOUT_ERR_EN.
- Defined: a timeout abort also sets err.
- Undefined: a timeout abort silently returns to IDLE and err reflects only start/parity/stop errors. The timeout counter and abort are present in both builds.

Test Plan:
- Scan code 8'h1C: frame 0,LSB-first data,parity=0,stop=1 at 12.5 kHz -> ready=1 and data=8'h1C one cycle after the stop fall; level=1; rd -> ready=0 next cycle.
- Frame 8'hF0 with parity bit inverted -> err=1, ready stays 0; clr -> err=0.
- Frame with stop bit=0 -> err=1, no push. A following good frame 8'h5A is still received correctly.
- 17 good frames, no rd, FIFO_AW=4 -> level=16, overflow=1, the 17th byte dropped. rd on the same cycle as the 17th push, repeated from a full FIFO -> accepted, overflow stays 0.
- Abort after 4 data bits (clock held high 6000 cycles):
  - FSM back in IDLE and no push.
  - err=1 with PS2_TIMEOUT_ERR_EN defined, err=0 without it.
  - A next full frame 8'h29 is received correctly.
- Clock glitches of FILTER-1 cycles low inside a bit period -> no extra bits, byte correct. reset asserted mid-frame -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, glitch filters, frame FSM with timeout, FWFT byte FIFO.
// Define PS2_TIMEOUT_ERR_EN to make a timeout abort also set err.
`timescale 1ns/1ps
module ps2_kbd_fifo #(
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned FILTER      = 8,
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_dat,
    input  logic             rd,
    input  logic             clr,
    output logic [7:0]       data,
    output logic             ready,
    output logic             overflow,
    output logic             err,
    output logic [FIFO_AW:0] level
);
    localparam int unsigned DEPTH = 2**FIFO_AW;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic             r_clk_f, r_dat_f, r_clk_f_d;
    logic [7:0]       r_clk_cnt, r_dat_cnt;
    logic             w_fall;
    state_t           r_state, w_state_nxt;
    logic [7:0]       r_sr;
    logic [2:0]       r_bitcnt;
    logic             r_par, r_ok;
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo, w_push, w_ferr, w_err_set;
    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wptr, r_rptr;
    logic             w_empty, w_full, w_pop, w_wr, w_drop;
    logic             r_ovf, r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
            r_clk_f   <= 1'b1;
            r_dat_f   <= 1'b1;
            r_clk_f_d <= 1'b1;
            r_clk_cnt <= '0;
            r_dat_cnt <= '0;
        end else begin
            r_clk_s1  <= ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_dat_s1  <= ps2_dat;
            r_dat_s2  <= r_dat_s1;
            r_clk_f_d <= r_clk_f;
            if (r_clk_s2 == r_clk_f) begin
                r_clk_cnt <= '0;
            end else if (r_clk_cnt == 8'(FILTER - 1)) begin
                r_clk_f   <= r_clk_s2;
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 8'd1;
            end
            if (r_dat_s2 == r_dat_f) begin
                r_dat_cnt <= '0;
            end else if (r_dat_cnt == 8'(FILTER - 1)) begin
                r_dat_f   <= r_dat_s2;
                r_dat_cnt <= '0;
            end else begin
                r_dat_cnt <= r_dat_cnt + 8'd1;
            end
        end
    end

    assign w_fall = r_clk_f_d & ~r_clk_f;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        w_tmo       = (r_state != S_IDLE) && (r_tmo == TMO_W'(TIMEOUT_CYC));
        if (w_tmo) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_dat_f) w_state_nxt = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (r_dat_f && r_ok) w_push = 1'b1;
                    else                 w_ferr = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_ok     <= 1'b0;
            r_tmo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE || w_fall) r_tmo <= '0;
            else                             r_tmo <= r_tmo + TMO_W'(1);
            if (w_fall && !w_tmo) begin
                case (r_state)
                    S_IDLE: begin
                        r_bitcnt <= '0;
                        r_par    <= 1'b0;
                    end
                    S_DATA: begin
                        r_sr     <= {r_dat_f, r_sr[7:1]};
                        r_par    <= r_par ^ r_dat_f;
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    S_PARITY: r_ok <= r_par ^ r_dat_f;
                    default: ;
                endcase
            end
        end
    end

    // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_pop   = rd & ~w_empty;
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

`ifdef PS2_TIMEOUT_ERR_EN
    assign w_err_set = w_ferr | w_tmo;
`else
    assign w_err_set = w_ferr;
`endif

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr[FIFO_AW-1:0]] <= r_sr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_drop)   r_ovf <= 1'b1;
            else if (clr) r_ovf <= 1'b0;
            if (w_err_set) r_err <= 1'b1;
            else if (clr)  r_err <= 1'b0;
        end
    end

    assign ready    = ~w_empty;
    assign data     = w_empty ? '0 : r_mem[r_rptr[FIFO_AW-1:0]];
    assign level    = r_wptr - r_rptr;
    assign overflow = r_ovf;
    assign err      = r_err;
endmodule
